cache_arbiter: RTL

- Shares the single physical-memory port between the I-cache and the D-cache of the 5-stage RV32I pipeline.
- Grants one line transaction at a time.
  - Reads: collects a cache line from a burst of beats.
  - Writes: splits a cache line into a burst of beats.
- Returns a one-cycle response to the granted cache.
- Sits between the two L1 caches and the memory interface. The pipeline stalls on the cache side while the arbiter serves another requester.

---
 rtl/cache_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one burst-oriented memory port between the I-cache and
// the D-cache. One line transaction is in flight at a time. A read collects
// BEATS memory beats into a line. A write sends the latched line out beat by
// beat. The granted cache then receives a single-cycle response.
//
// Handshake: each cache holds its request high until its one-cycle resp.
// Toward memory, pmem_read/pmem_write stay high for the whole burst. Every
// cycle with pmem_resp=1 accepts or delivers exactly one beat; cycles with
// pmem_resp=0 are stalls.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [BEAT_WIDTH-1:0] pmem_wdata,
    input  logic [BEAT_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [LINE_WIDTH-1:0] r_buf;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_owner_d;      // 1 = D-cache owns the current transaction
    logic                  r_last_grant_d; // 1 = last grant went to the D-cache

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_grant;
    logic                  w_grant_d;
    logic [ADDR_WIDTH-1:0] w_aligned_addr;

    assign w_i_req        = icache_read;
    assign w_d_req        = dcache_read | dcache_write;
    assign w_aligned_addr = (w_grant_d ? dcache_address : icache_address) & ~OFFSET_MASK;

    // Both caches see the line buffer at all times; it is meaningful only in RESP.
    assign icache_rdata = r_buf;
    assign dcache_rdata = r_buf;
    assign pmem_address = r_addr;

    // Arbitration, next-state and control outputs. On a tie the cache that did
    // not win last time is granted. A D-side write beats a simultaneous D-side read.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = w_d_req && (!w_i_req || !r_last_grant_d);
                    if (w_grant_d) begin
                        w_next_state = dcache_write ? D_WR : D_RD;
                    end else begin
                        w_next_state = I_RD;
                    end
                end
            end
            I_RD, D_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp && (r_cnt == LAST_BEAT)) begin
                    w_next_state = RESP;
                end
            end
            D_WR: begin
                pmem_write = 1'b1;
                if (pmem_resp && (r_cnt == LAST_BEAT)) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                icache_resp  = !r_owner_d;
                dcache_resp  = r_owner_d;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Present the write beat selected by the beat counter.
    always_comb begin
        pmem_wdata = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                pmem_wdata = r_wdata[b*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // State register; reset abandons any burst without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: latch the grant, then collect read beats or step through write beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_buf          <= '0;
            r_wdata        <= '0;
            r_addr         <= '0;
            r_owner_d      <= 1'b0;
            r_last_grant_d <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_addr         <= w_aligned_addr;
                        r_cnt          <= '0;
                        r_owner_d      <= w_grant_d;
                        r_last_grant_d <= w_grant_d;
                        if (w_grant_d && dcache_write) begin
                            r_wdata <= dcache_wdata;
                        end
                    end
                end
                I_RD, D_RD: begin
                    if (pmem_resp) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (r_cnt == CNT_W'(b)) begin
                                r_buf[b*BEAT_WIDTH +: BEAT_WIDTH] <= pmem_rdata;
                            end
                        end
                        r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                D_WR: begin
                    if (pmem_resp) begin
                        r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
